param_multicycle_cpu: RTL and testbench

- Next-generation multicycle CPU core with datapath width, register count and address width set by parameters.
- Adds a memory ready handshake with wait states, a Mem_Read strobe, separate read and write data buses, and a PC reset vector.
- Runs a FETCH/DECODE/EXEC/MEM sequencer.
- Sits between the board-level memory/IO fabric and the system top; one instance per system.

---
 rtl/param_multicycle_cpu.sv | 200 ++++++++++++++++++++
 tb/tb_param_multicycle_cpu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/param_multicycle_cpu.sv
// rtl/param_multicycle_cpu.sv - parameterised FETCH/DECODE/EXEC/MEM multicycle CPU core
// Optional retired-instruction counter output enabled by defining PMC_RETIRE_COUNT_EN.
module param_multicycle_cpu #(
    parameter int          DATA_W       = 16,
    parameter int          ADDR_W       = 16,
    parameter int          NUM_REGS     = 16,
    parameter int unsigned RESET_VECTOR = 0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Mem_Rd_Data,
    input  logic              Mem_Ready,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic              Mem_Read,
    output logic              Mem_Write,
    output logic [DATA_W-1:0] Mem_Wr_Data,
    output logic [2:0]        Flags
`ifdef PMC_RETIRE_COUNT_EN
    ,
    output logic [31:0]       Retire_Count
`endif
);

    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM} state_t;

    localparam logic [4:0] NREGS    = 5'(NUM_REGS);
    localparam logic [3:0] EXT_LOAD = 4'b0000;
    localparam logic [3:0] EXT_STOR = 4'b0100;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]        flags_q, flags_d;
    logic [DATA_W-1:0] regs_q [16];

    logic [3:0]        op, rd, ext, rs;
    logic [7:0]        imm8;
    logic [DATA_W-1:0] imm_sext, imm_zext, rf_a, rf_b, res, wr_data;
    logic [ADDR_W-1:0] disp;
    logic [DATA_W:0]   sum, diff, sumi;
    logic              is_load, is_stor, br_taken, wr_en, upd_nz, upd_c, c_new;

    assign op       = ir_q[15:12];
    assign rd       = ir_q[11:8];
    assign ext      = ir_q[7:4];
    assign rs       = ir_q[3:0];
    assign imm8     = ir_q[7:0];
    assign imm_sext = {{(DATA_W-8){imm8[7]}}, imm8};
    assign imm_zext = {{(DATA_W-8){1'b0}}, imm8};
    assign disp     = {{(ADDR_W-8){imm8[7]}}, imm8};
    assign is_load  = (ext == EXT_LOAD);
    assign is_stor  = (ext == EXT_STOR);

    // Out-of-range register indices read as zero.
    assign rf_a = ({1'b0, rd} < NREGS) ? regs_q[rd] : '0;
    assign rf_b = ({1'b0, rs} < NREGS) ? regs_q[rs] : '0;

    // Top bit of the widened difference is the unsigned borrow.
    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};
    assign sumi = {1'b0, a_q} + {1'b0, imm_sext};

    always_comb begin
        case (rd)
            4'b0000: br_taken = flags_q[0];
            4'b0001: br_taken = ~flags_q[0];
            4'b0010: br_taken = flags_q[1];
            4'b0011: br_taken = ~flags_q[1];
            4'b1110: br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        flags_d     = flags_q;
        wr_en       = 1'b0;
        wr_data     = '0;
        res         = '0;
        upd_nz      = 1'b0;
        upd_c       = 1'b0;
        c_new       = 1'b0;
        Mem_Addr    = pc_q;
        Mem_Read    = 1'b0;
        Mem_Write   = 1'b0;
        Mem_Wr_Data = '0;
        case (state_q)
            S_FETCH: begin
                Mem_Read = 1'b1;
                if (Mem_Ready) begin
                    ir_d    = Mem_Rd_Data[15:0];
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rf_a;
                b_d     = rf_b;
                state_d = (op == 4'b0100) ? S_MEM : S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    4'b0000: begin
                        case (ext)
                            4'b0101: begin res = sum[DATA_W-1:0];  c_new = sum[DATA_W];
                                           wr_en = 1'b1; upd_nz = 1'b1; upd_c = 1'b1; end
                            4'b1001: begin res = diff[DATA_W-1:0]; c_new = diff[DATA_W];
                                           wr_en = 1'b1; upd_nz = 1'b1; upd_c = 1'b1; end
                            4'b1011: begin res = diff[DATA_W-1:0]; c_new = diff[DATA_W];
                                           upd_nz = 1'b1; upd_c = 1'b1; end
                            4'b0001: begin res = a_q & b_q; wr_en = 1'b1; upd_nz = 1'b1; end
                            4'b0010: begin res = a_q | b_q; wr_en = 1'b1; upd_nz = 1'b1; end
                            4'b0011: begin res = a_q ^ b_q; wr_en = 1'b1; upd_nz = 1'b1; end
                            4'b1101: begin res = b_q; wr_en = 1'b1; end
                            default: ;
                        endcase
                    end
                    4'b0101: begin res = sumi[DATA_W-1:0]; c_new = sumi[DATA_W];
                                   wr_en = 1'b1; upd_nz = 1'b1; upd_c = 1'b1; end
                    4'b1101: begin res = imm_zext; wr_en = 1'b1; end
                    4'b1100: if (br_taken) pc_d = pc_q + disp;
                    default: ;
                endcase
                wr_data = res;
                if (upd_nz) begin
                    flags_d[2] = res[DATA_W-1];
                    flags_d[0] = (res == '0);
                end
                if (upd_c) flags_d[1] = c_new;
            end
            S_MEM: begin
                Mem_Addr = b_q[ADDR_W-1:0];
                if (is_load) begin
                    Mem_Read = 1'b1;
                    if (Mem_Ready) begin
                        wr_en   = 1'b1;
                        wr_data = Mem_Rd_Data;
                        state_d = S_FETCH;
                    end
                end else if (is_stor) begin
                    Mem_Write   = 1'b1;
                    Mem_Wr_Data = a_q;
                    if (Mem_Ready) state_d = S_FETCH;
                end else begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
        if (!Reset) begin
            Mem_Read    = 1'b0;
            Mem_Write   = 1'b0;
            Mem_Wr_Data = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= S_FETCH;
            pc_q    <= ADDR_W'(RESET_VECTOR);
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            flags_q <= '0;
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            flags_q <= flags_d;
            if (wr_en && ({1'b0, rd} < NREGS)) regs_q[rd] <= wr_data;
        end
    end

    assign Flags = flags_q;

`ifdef PMC_RETIRE_COUNT_EN
    logic        retire;
    logic [31:0] retire_q;

    assign retire = (state_q == S_EXEC) ||
                    ((state_q == S_MEM) && (Mem_Ready || !(is_load || is_stor)));

    always_ff @(posedge Clock) begin
        if (!Reset)      retire_q <= '0;
        else if (retire) retire_q <= retire_q + 32'd1;
    end

    assign Retire_Count = retire_q;
`endif

endmodule

// File: tb/tb_param_multicycle_cpu.sv
// tb/tb_param_multicycle_cpu.sv - table-driven self-checking bench for param_multicycle_cpu
module tb_param_multicycle_cpu;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Mem_Ready = 1'b1;
    logic [15:0] Mem_Rd_Data;
    logic [15:0] Mem_Addr;
    logic        Mem_Read, Mem_Write;
    logic [15:0] Mem_Wr_Data;
    logic [2:0]  Flags;
`ifdef PMC_RETIRE_COUNT_EN
    logic [31:0] Retire_Count;
`endif

    logic [15:0] mem [256];
    int checks = 0;
    int failures = 0;
    int wr_count = 0;

    param_multicycle_cpu #(
        .DATA_W(16), .ADDR_W(16), .NUM_REGS(8), .RESET_VECTOR(32'h0010)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Mem_Rd_Data(Mem_Rd_Data), .Mem_Ready(Mem_Ready),
        .Mem_Addr(Mem_Addr), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
        .Mem_Wr_Data(Mem_Wr_Data), .Flags(Flags)
`ifdef PMC_RETIRE_COUNT_EN
        , .Retire_Count(Retire_Count)
`endif
    );

    always #5 Clock = ~Clock;

    assign Mem_Rd_Data = mem[Mem_Addr[7:0]];

    always @(posedge Clock) if (Mem_Write && Mem_Ready) wr_count <= wr_count + 1;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] instr;
        logic [1:0]  kind;      // 0 alu/branch, 1 store, 2 load, 3 mem nop
        logic [15:0] maddr;
        logic [15:0] mdata;
        logic [2:0]  flags;
        logic [15:0] next;
    } rec_t;

    rec_t tbl [37];

    function automatic rec_t mk(input logic [15:0] a, input logic [15:0] i, input logic [1:0] k,
                                input logic [15:0] ma, input logic [15:0] md,
                                input logic [2:0] f, input logic [15:0] nx);
        rec_t r;
        r.addr = a; r.instr = i; r.kind = k; r.maddr = ma; r.mdata = md; r.flags = f; r.next = nx;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Entered and left at a negedge while the core sits in FETCH.
    task automatic run_rec(input rec_t r);
        mem[r.addr[7:0]] = r.instr;
        check("fetch_read", 32'(Mem_Read), 32'h1);
        check("fetch_addr", 32'(Mem_Addr), 32'(r.addr));
        @(posedge Clock); @(negedge Clock);
        @(posedge Clock); @(negedge Clock);
        case (r.kind)
            2'd1: begin
                check("stor_write", 32'(Mem_Write), 32'h1);
                check("stor_read", 32'(Mem_Read), 32'h0);
                check("stor_addr", 32'(Mem_Addr), 32'(r.maddr));
                check("stor_data", 32'(Mem_Wr_Data), 32'(r.mdata));
            end
            2'd2: begin
                check("load_read", 32'(Mem_Read), 32'h1);
                check("load_write", 32'(Mem_Write), 32'h0);
                check("load_addr", 32'(Mem_Addr), 32'(r.maddr));
            end
            default: begin
                check("noacc_read", 32'(Mem_Read), 32'h0);
                check("noacc_write", 32'(Mem_Write), 32'h0);
            end
        endcase
        @(posedge Clock); @(negedge Clock);
        check("flags", 32'(Flags), 32'(r.flags));
        check("next_fetch", 32'(Mem_Addr), 32'(r.next));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int wr_before;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h40] = 16'hBEEF;

        tbl[ 0] = mk(16'h10, 16'hD17F, 2'd0, 16'h0, 16'h0,    3'b000, 16'h11);
        tbl[ 1] = mk(16'h11, 16'hD201, 2'd0, 16'h0, 16'h0,    3'b000, 16'h12);
        tbl[ 2] = mk(16'h12, 16'h0152, 2'd0, 16'h0, 16'h0,    3'b000, 16'h13);
        tbl[ 3] = mk(16'h13, 16'h0292, 2'd0, 16'h0, 16'h0,    3'b001, 16'h14);
        tbl[ 4] = mk(16'h14, 16'hD340, 2'd0, 16'h0, 16'h0,    3'b001, 16'h15);
        tbl[ 5] = mk(16'h15, 16'h4143, 2'd1, 16'h40, 16'h0080, 3'b001, 16'h16);
        tbl[ 6] = mk(16'h16, 16'h4243, 2'd1, 16'h40, 16'h0000, 3'b001, 16'h17);
        tbl[ 7] = mk(16'h17, 16'hD5FF, 2'd0, 16'h0, 16'h0,    3'b001, 16'h18);
        tbl[ 8] = mk(16'h18, 16'h5501, 2'd0, 16'h0, 16'h0,    3'b000, 16'h19);
        tbl[ 9] = mk(16'h19, 16'h55FE, 2'd0, 16'h0, 16'h0,    3'b010, 16'h1A);
        tbl[10] = mk(16'h1A, 16'h4543, 2'd1, 16'h40, 16'h00FE, 3'b010, 16'h1B);
        tbl[11] = mk(16'h1B, 16'hD6F0, 2'd0, 16'h0, 16'h0,    3'b010, 16'h1C);
        tbl[12] = mk(16'h1C, 16'h0615, 2'd0, 16'h0, 16'h0,    3'b010, 16'h1D);
        tbl[13] = mk(16'h1D, 16'h0636, 2'd0, 16'h0, 16'h0,    3'b011, 16'h1E);
        tbl[14] = mk(16'h1E, 16'h0795, 2'd0, 16'h0, 16'h0,    3'b110, 16'h1F);
        tbl[15] = mk(16'h1F, 16'h4743, 2'd1, 16'h40, 16'hFF02, 3'b110, 16'h20);
        tbl[16] = mk(16'h20, 16'h0725, 2'd0, 16'h0, 16'h0,    3'b110, 16'h21);
        tbl[17] = mk(16'h21, 16'h05B7, 2'd0, 16'h0, 16'h0,    3'b010, 16'h22);
        tbl[18] = mk(16'h22, 16'h4543, 2'd1, 16'h40, 16'h00FE, 3'b010, 16'h23);
        tbl[19] = mk(16'h23, 16'h01D7, 2'd0, 16'h0, 16'h0,    3'b010, 16'h24);
        tbl[20] = mk(16'h24, 16'h4143, 2'd1, 16'h40, 16'hFFFE, 3'b010, 16'h25);
        tbl[21] = mk(16'h25, 16'hD955, 2'd0, 16'h0, 16'h0,    3'b010, 16'h26);
        tbl[22] = mk(16'h26, 16'h01D9, 2'd0, 16'h0, 16'h0,    3'b010, 16'h27);
        tbl[23] = mk(16'h27, 16'h4143, 2'd1, 16'h40, 16'h0000, 3'b010, 16'h28);
        tbl[24] = mk(16'h28, 16'h7123, 2'd0, 16'h0, 16'h0,    3'b010, 16'h29);
        tbl[25] = mk(16'h29, 16'h4111, 2'd3, 16'h0, 16'h0,    3'b010, 16'h2A);
        tbl[26] = mk(16'h2A, 16'hD180, 2'd0, 16'h0, 16'h0,    3'b010, 16'h2B);
        tbl[27] = mk(16'h2C, 16'h4403, 2'd2, 16'h40, 16'h0,    3'b010, 16'h2D);
        tbl[28] = mk(16'h2D, 16'h04B4, 2'd0, 16'h0, 16'h0,    3'b001, 16'h2E);
        tbl[29] = mk(16'h2E, 16'h4443, 2'd1, 16'h40, 16'hBEEF, 3'b001, 16'h2F);
        tbl[30] = mk(16'h2F, 16'hCEF0, 2'd0, 16'h0, 16'h0,    3'b001, 16'h20);
        tbl[31] = mk(16'h20, 16'hC0FE, 2'd0, 16'h0, 16'h0,    3'b001, 16'h1F);
        tbl[32] = mk(16'h1F, 16'hCE00, 2'd0, 16'h0, 16'h0,    3'b001, 16'h20);
        tbl[33] = mk(16'h20, 16'hC1FE, 2'd0, 16'h0, 16'h0,    3'b001, 16'h21);
        tbl[34] = mk(16'h21, 16'hC205, 2'd0, 16'h0, 16'h0,    3'b001, 16'h22);
        tbl[35] = mk(16'h22, 16'hC305, 2'd0, 16'h0, 16'h0,    3'b001, 16'h28);
        tbl[36] = mk(16'h28, 16'hC77F, 2'd0, 16'h0, 16'h0,    3'b001, 16'h29);

        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("rst_read", 32'(Mem_Read), 32'h0);
        check("rst_write", 32'(Mem_Write), 32'h0);
        check("rst_wdata", 32'(Mem_Wr_Data), 32'h0);
        Reset = 1'b1;
        #1;
        check("rel_read", 32'(Mem_Read), 32'h1);
        check("rel_addr", 32'(Mem_Addr), 32'h10);
        check("rel_flags", 32'(Flags), 32'h0);
`ifdef PMC_RETIRE_COUNT_EN
        check("retire_reset", Retire_Count, 32'd0);
`endif

        for (int i = 0; i < 27; i++) begin
            run_rec(tbl[i]);
`ifdef PMC_RETIRE_COUNT_EN
            if (i == 4) check("retire_five", Retire_Count, 32'd5);
`endif
        end

        // STOR r1 -> [0x40] with three wait states in MEM.
        mem[8'h2B] = 16'h4143;
        check("sw_fetch_addr", 32'(Mem_Addr), 32'h2B);
        wr_before = wr_count;
        @(posedge Clock); @(negedge Clock);
        Mem_Ready = 1'b0;
        @(posedge Clock);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clock);
            if (!Mem_Write) break;
            n++;
            check("sw_addr", 32'(Mem_Addr), 32'h40);
            check("sw_data", 32'(Mem_Wr_Data), 32'h0080);
            check("sw_read", 32'(Mem_Read), 32'h0);
            if (n == 4) Mem_Ready = 1'b1;
        end
        Mem_Ready = 1'b1;
        check("sw_cycles", 32'(2 + n), 32'd6);
        check("sw_next_read", 32'(Mem_Read), 32'h1);
        check("sw_next_addr", 32'(Mem_Addr), 32'h2C);
        check("sw_one_write", 32'(wr_count - wr_before), 32'd1);

        for (int i = 27; i < 37; i++) run_rec(tbl[i]);

        // Reset pulsed while a store waits in MEM.
        mem[8'h29] = 16'h4443;
        @(posedge Clock); @(negedge Clock);
        Mem_Ready = 1'b0;
        @(posedge Clock); @(negedge Clock);
        check("rm_write_pre", 32'(Mem_Write), 32'h1);
        wr_before = wr_count;
        Reset = 1'b0;
        Mem_Ready = 1'b1;
        #1;
        check("rm_write_forced", 32'(Mem_Write), 32'h0);
        check("rm_wdata_forced", 32'(Mem_Wr_Data), 32'h0);
        @(posedge Clock); @(negedge Clock);
        Reset = 1'b1;
        #1;
        check("rm_no_write", 32'(wr_count - wr_before), 32'd0);
        check("rm_pc_vector", 32'(Mem_Addr), 32'h10);
        check("rm_read", 32'(Mem_Read), 32'h1);
        check("rm_flags", 32'(Flags), 32'h0);
`ifdef PMC_RETIRE_COUNT_EN
        check("retire_after_reset", Retire_Count, 32'd0);
`endif
        run_rec(mk(16'h10, 16'h4443, 2'd1, 16'h0000, 16'h0000, 3'b000, 16'h11));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
